// File: rtl/stage_1_pkg.sv
// stage_1_pkg: shared constants and types for the stage_1 instruction fetch stage.
//   DEFAULT_RESET_PC / DEFAULT_NOP_INST : parameter defaults for stage_1
//   fetch_entry_t                       : one buffered {pc, inst} pair
//   req_state_e                         : instruction-memory request tracker states
package stage_1_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // IDLE: nothing outstanding; BUSY: request live, response will be kept;
    // DROP: request live, response belongs to a redirected-away path.
    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_BUSY = 2'd1,
        REQ_DROP = 2'd2
    } req_state_e;

endpackage

// File: rtl/stage_1_fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched {pc, inst} pairs between the memory
// response and the IF/ID output register.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, data_i  : write one entry (accepted when not full, or when popping)
//   pop_i           : drop the head entry (ignored when empty)
//   flush_i         : discard all entries; wins over push/pop
//   full_o, empty_o : occupancy flags
//   head_o          : oldest entry, valid when !empty_o
module fetch_buffer
    import stage_1_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        // A full buffer can still take a push when the head leaves this cycle.
        do_push = push_i && ((count_q != 2'd2) || do_pop);
    end

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/stage_1.sv
// stage_1: instruction fetch stage with a single-outstanding memory request,
// a 2-entry fetch buffer and the IF/ID output register.
//   i_clk, i_rst              : clock, asynchronous active-low reset
//   i_stall                   : hold inst/pc/inst_valid (buffer keeps filling)
//   i_b_taken, i_b_pc         : redirect fetch to i_b_pc (word aligned)
//   imem_req, imem_addr       : memory request, held until acknowledged
//   i_imem_ack, i_imem_data   : memory response
//   inst, pc, inst_valid      : instruction handed to decode
module stage_1
    import stage_1_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid
);

    req_state_e   state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;

    logic         buf_push;
    logic         buf_pop;
    logic         buf_full;
    logic         buf_empty;
    logic         room_next;
    fetch_entry_t buf_wdata;
    fetch_entry_t buf_head;

    fetch_buffer u_fetch_buffer (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (i_b_taken),
        .data_i  (buf_wdata),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .head_o  (buf_head)
    );

    always_comb begin
        buf_pop        = !i_b_taken && !i_stall && !buf_empty;
        buf_push       = (state_q == REQ_BUSY) && i_imem_ack && !i_b_taken;
        buf_wdata.pc   = fetch_pc_q;
        buf_wdata.inst = i_imem_data;
        // Occupancy after this edge is at most one, so a new request still fits.
        room_next = buf_empty
                 || (!buf_full && (buf_pop || !buf_push))
                 || (buf_full && buf_pop && !buf_push);
    end

    // Request tracker: a kept ack may immediately chain the next request;
    // a dropped ack always leaves one idle cycle before the redirected fetch.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            REQ_IDLE: begin
                if (!i_b_taken && room_next) begin
                    state_d = REQ_BUSY;
                end
            end
            REQ_BUSY: begin
                if (i_imem_ack) begin
                    state_d = (!i_b_taken && room_next) ? REQ_BUSY : REQ_IDLE;
                end else if (i_b_taken) begin
                    state_d     = REQ_DROP;
                    drop_addr_d = fetch_pc_q;
                end
            end
            REQ_DROP: begin
                if (i_imem_ack) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
        if (buf_push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (i_b_taken) begin
            fetch_pc_d = i_b_pc & ~32'd3;
        end
    end

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (i_b_taken) begin
            inst_d  = NOP_INST;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (!i_stall) begin
            if (!buf_empty) begin
                inst_d  = buf_head.inst;
                pc_d    = buf_head.pc;
                valid_d = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                pc_d    = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= REQ_IDLE;
            fetch_pc_q  <= RESET_PC & ~32'd3;
            drop_addr_q <= '0;
            inst_q      <= NOP_INST;
            pc_q        <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
        end
    end

    // While dropping, the abandoned request's address stays on the bus.
    assign imem_req   = (state_q != REQ_IDLE);
    assign imem_addr  = (state_q == REQ_DROP) ? drop_addr_q : fetch_pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_stage_1.sv
// Self-checking bench for stage_1: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch stage.
module tb_stage_1;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        bt = 1'b0;
    logic [31:0] bpc = '0;
    logic        ack = 1'b0;
    logic [31:0] idata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;

    int checks = 0;
    int failures = 0;

    stage_1 #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_stall     (stall),
        .i_b_taken   (bt),
        .i_b_pc      (bpc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .i_imem_ack  (ack),
        .i_imem_data (idata),
        .inst        (inst),
        .pc          (pc),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    // Reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    bit          m_req;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    logic [31:0] m_inst;
    logic [31:0] m_opc;
    bit          m_valid;

    task automatic model_reset();
        mq.delete();
        m_req   = 0;
        m_drop  = 0;
        m_pc    = 32'h0;
        m_daddr = 32'h0;
        m_inst  = NOP;
        m_opc   = 32'h0;
        m_valid = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        bit   keep;
        keep = m_req && !m_drop && ack && !bt;
        if (bt) begin
            m_inst = NOP; m_opc = 0; m_valid = 0;
            mq.delete();
        end else begin
            if (!stall) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_inst = e.inst; m_opc = e.pc; m_valid = 1;
                end else begin
                    m_inst = NOP; m_opc = 0; m_valid = 0;
                end
            end
            if (keep) mq.push_back('{m_pc, idata});
        end
        if (bt) begin
            if (m_req && !ack) begin
                if (!m_drop) m_daddr = m_pc;
                m_drop = 1;
            end else begin
                m_req = 0; m_drop = 0;
            end
            m_pc = bpc & ~32'd3;
        end else if (m_req) begin
            if (ack) begin
                if (m_drop) begin
                    m_req = 0; m_drop = 0;
                end else begin
                    m_pc  = m_pc + 32'd4;
                    m_req = (mq.size() < 2);
                end
            end
        end else begin
            m_req = (mq.size() < 2);
        end
    endtask

    // Drive inputs now, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input bit s, input bit b, input logic [31:0] t,
                        input bit a, input logic [31:0] d);
        stall = s; bt = b; bpc = t; ack = a; idata = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        bt    = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (inst !== NOP) begin failures++; $display("FAIL reset_inst: got %h expected %h", inst, NOP); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", pc); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        ack = 1'b0;
        apply_reset();
        // stray ack on the first edge is ignored; first request goes out
        step(0, 0, 0, 1, 32'hCAFE_0000);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h expected 0", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL first_valid: got %b expected 0", inst_valid); end
    endtask

    task automatic test_basic();
        apply_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0010_0093);
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL basic_addr4: got %h expected 4", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL basic_lat: got %b expected 0", inst_valid); end
        step(0, 0, 0, 1, 32'h0020_0113);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL basic_pc0: got %h expected 0", pc); end
        checks++; if (inst !== 32'h0010_0093) begin failures++; $display("FAIL basic_inst0: got %h expected 00100093", inst); end
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL basic_valid0: got %b expected 1", inst_valid); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL basic_pc4: got %h expected 4", pc); end
        checks++; if (inst !== 32'h0020_0113) begin failures++; $display("FAIL basic_inst4: got %h expected 00200113", inst); end
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL basic_valid4: got %b expected 1", inst_valid); end
        checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin failures++; $display("FAIL basic_req8: got req=%b addr=%h expected req=1 addr=8", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 1, 32'h0030_0193);
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL stall_hold1: got %h expected 4", pc); end
        step(1, 0, 0, 1, 32'h0040_0213);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_full_req: got %b expected 0", imem_req); end
        step(1, 0, 0, 1, 32'h0BAD_0BAD);
        checks++; if (pc !== 32'h4 || inst !== 32'h0020_0113 || inst_valid !== 1'b1) begin failures++; $display("FAIL stall_hold3: got pc=%h inst=%h v=%b expected pc=4 inst=00200113 v=1", pc, inst, inst_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_full_req2: got %b expected 0", imem_req); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h8 || inst !== 32'h0030_0193) begin failures++; $display("FAIL stall_rel8: got pc=%h inst=%h expected pc=8 inst=00300193", pc, inst); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL stall_req10: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'hC || inst !== 32'h0040_0213 || inst_valid !== 1'b1) begin failures++; $display("FAIL stall_relC: got pc=%h inst=%h v=%b expected pc=c inst=00400213 v=1", pc, inst, inst_valid); end
        step(0, 0, 0, 0, 0);
        checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin failures++; $display("FAIL stall_drain: got inst=%h v=%b expected inst=%h v=0", inst, inst_valid, NOP); end
    endtask

    task automatic test_redirect_pending();
        step(0, 1, 32'h103, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL drop_hold: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin failures++; $display("FAIL drop_nop: got inst=%h v=%b expected inst=%h v=0", inst, inst_valid, NOP); end
        step(0, 0, 0, 0, 0);
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL drop_hold2: got %h expected 10", imem_addr); end
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL drop_ack: got req=%b v=%b expected req=0 v=0", imem_req, inst_valid); end
        step(0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL drop_newreq: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL drop_noleak: got %b expected 0", inst_valid); end
        step(0, 0, 0, 1, 32'h1110_0113);
        step(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h100 || inst !== 32'h1110_0113) begin failures++; $display("FAIL drop_out: got pc=%h inst=%h expected pc=100 inst=11100113", pc, inst); end
    endtask

    task automatic test_redirect_ack();
        apply_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_00A0);
        step(0, 0, 0, 1, 32'h0000_00A4);
        step(1, 1, 32'h40, 1, 32'h0BAD_0BAD);
        checks++; if (inst !== NOP || inst_valid !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL rda_nop: got inst=%h pc=%h v=%b expected inst=%h pc=0 v=0", inst, pc, inst_valid, NOP); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rda_req: got %b expected 0", imem_req); end
        step(0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL rda_req40: got req=%b addr=%h expected req=1 addr=40", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rda_flushed: got %b expected 0", inst_valid); end
        step(0, 0, 0, 1, 32'h0400_0093);
        step(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h40 || inst !== 32'h0400_0093) begin failures++; $display("FAIL rda_out: got pc=%h inst=%h expected pc=40 inst=04000093", pc, inst); end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0BAD);
        step(0, 0, 0, 0, 0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top: got %h expected fffffffc", imem_addr); end
        step(0, 0, 0, 1, 32'h0F0F_0F0F);
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_zero: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        step(0, 0, 0, 1, 32'h1E1E_1E1E);
        checks++; if (pc !== 32'hFFFF_FFFC || inst !== 32'h0F0F_0F0F) begin failures++; $display("FAIL wrap_out1: got pc=%h inst=%h expected pc=fffffffc inst=0f0f0f0f", pc, inst); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h0 || inst !== 32'h1E1E_1E1E || inst_valid !== 1'b1) begin failures++; $display("FAIL wrap_out2: got pc=%h inst=%h v=%b expected pc=0 inst=1e1e1e1e v=1", pc, inst, inst_valid); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0050_0293);
        step(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || pc !== 32'h0) begin failures++; $display("FAIL rstmid_async: got req=%b v=%b inst=%h pc=%h expected req=0 v=0 inst=%h pc=0", imem_req, inst_valid, inst, pc, NOP); end
        ack = 1'b1;
        apply_reset();
        step(0, 0, 0, 1, 32'hBADB_AD00);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rstmid_restart: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", imem_req, imem_addr, inst_valid); end
        step(0, 0, 0, 1, 32'h0060_0313);
        step(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h0 || inst !== 32'h0060_0313) begin failures++; $display("FAIL rstmid_out: got pc=%h inst=%h expected pc=0 inst=00600313", pc, inst); end
    endtask

    task automatic test_random();
        logic [31:0] exp_addr;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 9) < 6, $urandom);
            exp_addr = m_drop ? m_daddr : m_pc;
            checks++; if (imem_req !== m_req) begin failures++; $display("FAIL rnd_req cyc=%0d: got %b expected %b", c, imem_req, m_req); end
            if (m_req) begin
                checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d: got %h expected %h", c, imem_addr, exp_addr); end
            end
            checks++; if (inst !== m_inst) begin failures++; $display("FAIL rnd_inst cyc=%0d: got %h expected %h", c, inst, m_inst); end
            checks++; if (pc !== m_opc) begin failures++; $display("FAIL rnd_pc cyc=%0d: got %h expected %h", c, pc, m_opc); end
            checks++; if (inst_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d: got %b expected %b", c, inst_valid, m_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_pending();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
